scan_chain_ctrl: RTL and testbench
==================================

Name: scan_chain_ctrl

Overview:
- Test-side driver for a single internal scan chain, such as the 8-bit scan counter.
- Loads a stimulus pattern serially, pulses functional mode for a set number of capture cycles, unloads the captured state, and compares it against an expected response.
- Sits between the test sequencer or JTAG-style front end and the chain's scan_en, scan_in, enable and scan_out pins.

Parameters:
- CHAIN_LEN, 8, number of flops in the target chain (>=2).
- CAPTURE_CYCLES, 1, functional clocks with func_en=1 between load and unload (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a load/capture/unload/compare sequence; sampled in IDLE only.
- pattern  in  CHAIN_LEN  stimulus to load; latched on accepted start.
- expected  in  CHAIN_LEN  expected captured state; latched on accepted start.
- scan_out_dut  in  1  serial output of the chain (its MSB).
- scan_en  out  1  drives chain scan enable.
- scan_in  out  1  drives chain serial input.
- func_en  out  1  drives chain functional enable (e.g. counter enable).
- busy  out  1  high from the cycle after start acceptance through DONE.
- done  out  1  one-cycle pulse; result valid.
- pass  out  1  captured == expected (after mask); held until next accepted start.
- captured  out  CHAIN_LEN  unloaded chain contents; held until next accepted start.

Behaviour:
- Reset (async, rst=1): state=IDLE. scan_en, scan_in, func_en, busy, done and pass = 0. captured=0. Bit and cycle counters = 0.
- Chain convention: a shift moves every bit one place toward the MSB; scan_in enters the LSB; scan_out_dut = MSB.
- States: IDLE -> SHIFT -> CAPTURE -> UNLOAD -> DONE -> IDLE.
- IDLE:
  - All scan and func outputs are 0.
  - start=1 at an edge latches pattern and expected, clears pass and captured, and goes to SHIFT.
- SHIFT (CHAIN_LEN cycles):
  - scan_en=1.
  - scan_in = pattern bit CHAIN_LEN-1-k in cycle k, MSB first, so the chain holds pattern exactly after the last edge.
- CAPTURE (CAPTURE_CYCLES cycles): scan_en=0, func_en=1, scan_in=0.
- UNLOAD (CHAIN_LEN cycles):
  - scan_en=1, scan_in=0.
  - On each edge: captured <= {captured[CHAIN_LEN-2:0], scan_out_dut}.
  - After the last edge, captured equals the chain state at the end of CAPTURE.
  - On that same last edge, pass is registered from the final shift value compared with expected.
- DONE (1 cycle): done=1, busy=1, all chain drives 0, then IDLE.
- Latency: the start edge is followed by 2*CHAIN_LEN + CAPTURE_CYCLES cycles of busy, then 1 DONE cycle.
- Outputs scan_en, scan_in, func_en, busy and done are decoded from registered state and counters only. There is no combinational path from start or scan_out_dut to any output.
- start while not in IDLE is ignored. Changes to pattern or expected after acceptance have no effect.
- start high continuously triggers back-to-back sequences, each starting from the IDLE cycle after DONE.
- rst mid-sequence returns to IDLE immediately with all outputs at reset values. There is no done pulse. Partial chain contents are abandoned.
- Counters are sized to clog2(max(CHAIN_LEN, CAPTURE_CYCLES)+1) and never wrap within a state.

Optional Feature:
- Macro: SCAN_CTRL_MASK_EN.
- Defined:
  - Adds input port compare_mask (CHAIN_LEN), latched with expected on start.
  - Bits with mask=1 are don't-care: pass = ((captured ^ expected) & ~mask) == 0.
- Undefined:
  - No mask port.
  - pass = (captured == expected).

Test Plan:
- CHAIN_LEN=8, CAPTURE_CYCLES=1, behavioral scan counter attached, pattern=0x5A, expected=0x5B -> scan_in sequence 0,1,0,1,1,0,1,0; func_en high 1 cycle; captured=0x5B; pass=1; done 18 cycles after the start edge.
- pattern=0xFF, expected=0x00 (increment wrap) -> captured=0x00, pass=1.
- pattern=0x10, expected=0x12, CAPTURE_CYCLES=1 -> captured=0x11, pass=0, done still pulses once.
- rst asserted during SHIFT cycle 3 -> all outputs 0 immediately, no done. A subsequent start with 0x00/0x01 -> pass=1.
- start held high through a sequence with a different pattern presented mid-sequence -> ignored. The second run begins after DONE using values sampled then; done pulses exactly once per run.
- With SCAN_CTRL_MASK_EN: pattern=0x5A, expected=0x5F, mask=0x0F -> pass=1. Same with mask=0x00 -> pass=0.

Source files
------------

// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: drives one internal scan chain through a test sequence:
// serial load of a stimulus pattern (MSB first), a run of functional capture
// clocks, serial unload of the captured state, then a compare against the
// expected response.
//
// Chain convention: each shift moves bits toward the MSB, scan_in enters the
// LSB and scan_out_dut is the chain MSB.
//
// Optional feature: define SCAN_CTRL_MASK_EN to add a compare_mask port.
// Mask bits set to 1 are ignored by the compare.
//
// Handshake: start is a level request that is only looked at in IDLE. A high
// start at an IDLE clock edge is the accepted request. busy then stays high
// until the DONE cycle has ended, and done is high for that one DONE cycle.
// The result (captured, pass) is valid from done until the next accepted start.
module scan_chain_ctrl #(
    parameter int CHAIN_LEN      = 8,
    parameter int CAPTURE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
`ifdef SCAN_CTRL_MASK_EN
    input  logic [CHAIN_LEN-1:0] compare_mask,
`endif
    input  logic                 scan_out_dut,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic                 func_en,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] captured
);

    // One counter serves every timed state, so size it for the longest one.
    localparam int MAX_CNT = (CHAIN_LEN > CAPTURE_CYCLES) ? CHAIN_LEN : CAPTURE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CAPTURE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_UNLOAD  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    // The pattern is held in a shift register, so scan_in always comes from
    // its MSB. That keeps scan_in a plain register output.
    logic [CHAIN_LEN-1:0] pat_sh_q, pat_sh_d;
    logic [CHAIN_LEN-1:0] exp_q, exp_d;
    logic [CHAIN_LEN-1:0] captured_q, captured_d;
    logic                 pass_q, pass_d;
`ifdef SCAN_CTRL_MASK_EN
    logic [CHAIN_LEN-1:0] mask_q, mask_d;
`endif

    logic [CHAIN_LEN-1:0] unload_word;
    logic                 match;

    // Value that captured takes at the next unload edge, and its compare.
    assign unload_word = {captured_q[CHAIN_LEN-2:0], scan_out_dut};
`ifdef SCAN_CTRL_MASK_EN
    assign match = (((unload_word ^ exp_q) & ~mask_q) == '0);
`else
    assign match = (unload_word == exp_q);
`endif

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter and chain drives. The outputs depend only on
    // registered state, never on start or scan_out_dut.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        scan_en = 1'b0;
        scan_in = 1'b0;
        func_en = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                scan_en = 1'b1;
                scan_in = pat_sh_q[CHAIN_LEN-1];
                busy    = 1'b1;
                if (cnt_q == SHIFT_LAST) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                func_en = 1'b1;
                busy    = 1'b1;
                if (cnt_q == CAP_LAST) begin
                    state_d = ST_UNLOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_UNLOAD: begin
                scan_en = 1'b1;
                busy    = 1'b1;
                if (cnt_q == SHIFT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Next values for the datapath: latch on accept, shift out while
    // loading, shift in while unloading, and register the compare on the
    // final unload edge.
    always_comb begin
        pat_sh_d   = pat_sh_q;
        exp_d      = exp_q;
        captured_d = captured_q;
        pass_d     = pass_q;
`ifdef SCAN_CTRL_MASK_EN
        mask_d     = mask_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pat_sh_d   = pattern;
                    exp_d      = expected;
                    captured_d = '0;
                    pass_d     = 1'b0;
`ifdef SCAN_CTRL_MASK_EN
                    mask_d     = compare_mask;
`endif
                end
            end
            ST_SHIFT: begin
                pat_sh_d = {pat_sh_q[CHAIN_LEN-2:0], 1'b0};
            end
            ST_UNLOAD: begin
                captured_d = unload_word;
                if (cnt_q == SHIFT_LAST) begin
                    pass_d = match;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_sh_q   <= '0;
            exp_q      <= '0;
            captured_q <= '0;
            pass_q     <= 1'b0;
`ifdef SCAN_CTRL_MASK_EN
            mask_q     <= '0;
`endif
        end else begin
            pat_sh_q   <= pat_sh_d;
            exp_q      <= exp_d;
            captured_q <= captured_d;
            pass_q     <= pass_d;
`ifdef SCAN_CTRL_MASK_EN
            mask_q     <= mask_d;
`endif
        end
    end

    assign captured = captured_q;
    assign pass     = pass_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl. An 8-bit scan counter is attached: it shifts
// when scan_en is high and increments when func_en is high. A sequence-level
// model predicts every output on every cycle. Directed runs pin the model
// with literal values.
module tb_scan_chain_ctrl;
  localparam int CL = 8;
  localparam int CC = 1;
  localparam int DONE_J = 2 * CL + CC + 1;
`ifdef SCAN_CTRL_MASK_EN
  localparam bit MASK_ON = 1'b1;
`else
  localparam bit MASK_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, scan_out_dut;
  logic [CL-1:0] pattern, expected, compare_mask;
  logic scan_en, scan_in, func_en, busy, done, pass;
  logic [CL-1:0] captured;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  scan_chain_ctrl #(.CHAIN_LEN(CL), .CAPTURE_CYCLES(CC)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .pattern(pattern),
    .expected(expected),
`ifdef SCAN_CTRL_MASK_EN
    .compare_mask(compare_mask),
`endif
    .scan_out_dut(scan_out_dut),
    .scan_en(scan_en),
    .scan_in(scan_in),
    .func_en(func_en),
    .busy(busy),
    .done(done),
    .pass(pass),
    .captured(captured)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- attached scan counter ----------------
  logic [CL-1:0] chain_q = '0;
  assign scan_out_dut = chain_q[CL-1];
  always @(posedge clk) begin
    if (scan_en) chain_q <= {chain_q[CL-2:0], scan_in};
    else if (func_en) chain_q <= chain_q + 8'd1;
  end

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_j: 0 when idle, otherwise the 1-based index of the cycle since the start edge.
  int m_j = 0;
  logic [CL-1:0] m_pat = '0, m_exp = '0, m_msk = '0, m_final = '0;
  logic [CL-1:0] m_held_cap = '0;
  logic m_held_pass = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_j = 0;
      m_held_cap = '0;
      m_held_pass = 1'b0;
    end else if (m_j == 0) begin
      if (start) begin
        m_j = 1;
        m_pat = pattern;
        m_exp = expected;
        m_msk = MASK_ON ? compare_mask : '0;
        m_final = pattern + 8'(CC);  // counter adds one per capture cycle
        m_held_cap = '0;
        m_held_pass = 1'b0;
      end
    end else if (m_j == DONE_J) begin
      m_j = 0;
    end else begin
      m_j++;
      if (m_j == DONE_J) begin
        m_held_cap = m_final;
        m_held_pass = (((m_final ^ m_exp) & ~m_msk) == '0);
      end
    end
  end

  // compare process: every cycle on the falling edge
  always @(negedge clk) begin
    if (chk_on) begin
      logic e_se, e_si, e_fe;
      logic [CL-1:0] e_cap;
      int u;
      e_se = ((m_j >= 1) && (m_j <= CL)) || ((m_j > CL + CC) && (m_j < DONE_J));
      e_si = ((m_j >= 1) && (m_j <= CL)) ? m_pat[CL - m_j] : 1'b0;
      e_fe = (m_j > CL) && (m_j <= CL + CC);
      if (m_j == 0 || m_j >= DONE_J) e_cap = m_held_cap;
      else if (m_j <= CL + CC) e_cap = '0;
      else begin
        u = m_j - (CL + CC + 1);
        e_cap = (u == 0) ? '0 : (m_final >> (CL - u));
      end
      check("scan_en", 32'(scan_en), 32'(e_se));
      check("scan_in", 32'(scan_in), 32'(e_si));
      check("func_en", 32'(func_en), 32'(e_fe));
      check("busy", 32'(busy), 32'(m_j != 0));
      check("done", 32'(done), 32'(m_j == DONE_J));
      check("pass", 32'(pass), 32'(m_held_pass));
      check("captured", 32'(captured), 32'(e_cap));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_seq(input logic [CL-1:0] pat, input logic [CL-1:0] exv, input logic [CL-1:0] msk,
                         output logic [CL-1:0] cap, output logic p, output int lat,
                         output logic [CL-1:0] seq, output int fcnt, output int dcnt);
    @(posedge clk); #1;
    start = 1'b1; pattern = pat; expected = exv; compare_mask = msk;
    @(posedge clk); #1;
    start = 1'b0;
    pattern = 8'($urandom); expected = 8'($urandom); compare_mask = 8'($urandom);
    lat = 0; seq = '0; fcnt = 0; dcnt = 0;
    for (int j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (j <= CL) seq = {seq[CL-2:0], scan_in};
      if (func_en) fcnt++;
      if (done) begin
        dcnt++;
        if (lat == 0) lat = j;
      end
      if (lat != 0 && j >= lat + 2) break;
    end
    check("done_seen_within_budget", 32'(lat != 0), 32'd1);
    cap = captured;
    p = pass;
  endtask

  // ---------------- stimulus ----------------
  logic [CL-1:0] cap, seq;
  logic p;
  int lat, fcnt, dcnt;

  initial begin
    rst = 1'b0; start = 1'b0; pattern = '0; expected = '0; compare_mask = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_scan_en", 32'(scan_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_captured", 32'(captured), 32'd0);
    rst = 1'b0;
    chk_on = 1'b1;

    // basic increment capture
    run_seq(8'h5A, 8'h5B, 8'h00, cap, p, lat, seq, fcnt, dcnt);
    check("t1_scan_in_seq", 32'(seq), 32'h5A);
    check("t1_func_cycles", 32'(fcnt), 32'd1);
    check("t1_captured", 32'(cap), 32'h5B);
    check("t1_pass", 32'(p), 32'd1);
    check("t1_done_latency", 32'(lat), 32'd18);
    check("t1_done_count", 32'(dcnt), 32'd1);

    // wrap
    run_seq(8'hFF, 8'h00, 8'h00, cap, p, lat, seq, fcnt, dcnt);
    check("t2_captured", 32'(cap), 32'h00);
    check("t2_pass", 32'(p), 32'd1);

    // mismatch
    run_seq(8'h10, 8'h12, 8'h00, cap, p, lat, seq, fcnt, dcnt);
    check("t3_captured", 32'(cap), 32'h11);
    check("t3_pass", 32'(p), 32'd0);
    check("t3_done_count", 32'(dcnt), 32'd1);

    // reset during SHIFT cycle 3
    @(posedge clk); #1;
    start = 1'b1; pattern = 8'h3C; expected = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t4_rst_scan_en", 32'(scan_en), 32'd0);
    check("t4_rst_scan_in", 32'(scan_in), 32'd0);
    check("t4_rst_func_en", 32'(func_en), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_done", 32'(done), 32'd0);
    check("t4_rst_pass", 32'(pass), 32'd0);
    check("t4_rst_captured", 32'(captured), 32'd0);
    dcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    @(posedge clk); #1 rst = 1'b0;
    check("t4_no_done", 32'(dcnt), 32'd0);
    run_seq(8'h00, 8'h01, 8'h00, cap, p, lat, seq, fcnt, dcnt);
    check("t4_after_pass", 32'(p), 32'd1);

    // start held high, pattern changed mid-run
    @(posedge clk); #1;
    start = 1'b1; pattern = 8'hC3; expected = 8'hC4;
    @(posedge clk); #1;
    pattern = 8'h3C; expected = 8'h3D;
    dcnt = 0;
    for (int j = 1; j <= 45; j++) begin
      @(negedge clk);
      if (done) dcnt++;
      if (j == 18) check("t5_first_captured", 32'(captured), 32'hC4);
      if (j == 20) start = 1'b0;
      if (j == 25) begin pattern = 8'hAA; expected = 8'h55; end
    end
    check("t5_done_count", 32'(dcnt), 32'd2);
    check("t5_second_captured", 32'(captured), 32'h3D);
    check("t5_second_pass", 32'(pass), 32'd1);

    // mask behaviour (without the mask port the compare is exact)
    run_seq(8'h5A, 8'h5F, 8'h0F, cap, p, lat, seq, fcnt, dcnt);
    check("t6_pass_mask_0f", 32'(p), MASK_ON ? 32'd1 : 32'd0);
    run_seq(8'h5A, 8'h5F, 8'h00, cap, p, lat, seq, fcnt, dcnt);
    check("t6_pass_mask_00", 32'(p), 32'd0);

    // randomized runs
    for (int i = 0; i < 24; i++) begin
      logic [CL-1:0] rp, re, rm;
      rp = 8'($urandom_range(0, 255));
      re = ($urandom_range(0, 1) == 1) ? rp + 8'd1 : 8'($urandom_range(0, 255));
      rm = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_seq(rp, re, rm, cap, p, lat, seq, fcnt, dcnt);
      check("rnd_latency", 32'(lat), 32'd18);
      check("rnd_done_count", 32'(dcnt), 32'd1);
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // time limit for the whole run
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
